// File: rtl/lift_disp_pkg.sv
// -----------------------------------------------------------------------------
// lift_disp_pkg
//   Shared definitions for the lift 7-segment producer path: display code
//   values understood by the segment decoder, direction encodings, digit
//   count and small helpers that map lift status onto display codes.
// -----------------------------------------------------------------------------
package lift_disp_pkg;

    // Display codes consumed by the code-to-segment decoder
    localparam logic [3:0] C_DOWN0      = 4'd0;
    localparam logic [3:0] C_DOWN1      = 4'd1;
    localparam logic [3:0] C_UP0        = 4'd2;
    localparam logic [3:0] C_UP1        = 4'd3;
    localparam logic [3:0] C_FLOOR_BASE = 4'd4;
    localparam logic [3:0] C_ALARM      = 4'd9;
    localparam logic [3:0] C_OFF        = 4'd10;

    // Direction encodings from the lift controller (2'b11 behaves as idle)
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int         NUM_DIGITS = 4;
    localparam logic [2:0] MAX_FLOOR  = 3'd4;
    localparam int         IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [IDX_W-1:0] digit_idx_t;

    // One registered display sample: code for the decoder plus anodes
    typedef struct packed {
        logic [3:0]            code;
        logic [NUM_DIGITS-1:0] an;
    } disp_out_t;

    // True only for the two directions that animate
    function automatic logic dir_moving(input logic [1:0] d);
        return (d == DIR_UP) || (d == DIR_DOWN);
    endfunction

    // Floor digit; out-of-range floors blank the digit
    function automatic logic [3:0] floor_code(input logic [2:0] fl);
        if (fl <= MAX_FLOOR)
            return C_FLOOR_BASE + {1'b0, fl};
        else
            return C_OFF;
    endfunction

    // Direction digit: arrow frame selected by the animation bit
    function automatic logic [3:0] dir_code(input logic [1:0] d, input logic frame);
        case (d)
            DIR_UP:   return frame ? C_UP1 : C_UP0;
            DIR_DOWN: return frame ? C_DOWN1 : C_DOWN0;
            default:  return C_OFF;
        endcase
    endfunction

    // Active-low one-hot anode for the selected digit
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Free-running modulo-DIV counter with enable and synchronous clear.
//   tick_o is high for the single cycle in which the counter wraps from
//   DIV-1 back to 0. A clear in the same cycle suppresses the tick and
//   restarts the count at 0.
//
//   Ports
//     clk    : clock
//     rst_n  : asynchronous active-low reset (counter -> 0)
//     en_i   : count enable
//     clr_i  : synchronous clear, wins over enable and wrap
//     tick_o : wrap strobe (combinational from count, enable and clear)
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i & ~clr_i & (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lift_disp_encoder.sv
// -----------------------------------------------------------------------------
// lift_disp_encoder
//   Producer side of the lift 4-digit 7-segment display. Scans the digits,
//   one at a time, and registers the display code for the selected digit
//   together with its active-low anode.
//     digit 0 : floor (floor+4, blank when floor > 4)
//     digit 1 : direction arrow, two-frame animation
//     digit 2,3 : blank
//   An active alarm overrides every digit with a blinking alarm symbol while
//   the anodes keep scanning. enable=0 blanks the display but leaves every
//   counter running so re-enabling picks up mid-scan.
//
//   Ports
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     enable : 1 = display on, 0 = all anodes off
//     floor  : current floor, legal 0..4
//     dir    : 00 idle, 01 up, 10 down, 11 idle
//     alarm  : alarm level
//     code   : registered display code to the segment decoder
//     an     : registered digit anodes, active-low
// -----------------------------------------------------------------------------
module lift_disp_encoder
    import lift_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int ANIM_DIV  = 25000000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [2:0]            floor,
    input  logic [1:0]            dir,
    input  logic                  alarm,
    output logic [3:0]            code,
    output logic [NUM_DIGITS-1:0] an
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    digit_idx_t idx_q, idx_d;
    logic [1:0] dir_q;              // previous dir, for change detection
    logic       alarm_q;            // previous alarm, for rise detection
    logic       frame_q, frame_d;   // arrow animation frame
    logic       phase_q, phase_d;   // alarm blink phase (1 = blanked)
    disp_out_t  out_q, out_d;

    logic scan_tick, anim_tick, blink_tick;
    logic anim_en, anim_clr;
    logic blink_en, blink_clr;
    logic dir_chg, alarm_rise;

    // ------------------------------------------------------------------
    // Prescalers
    // ------------------------------------------------------------------
    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .clr_i  (1'b0),
        .tick_o (scan_tick)
    );

    // Any dir change restarts the animation; idle parks it at zero.
    assign dir_chg  = (dir != dir_q);
    assign anim_en  = dir_moving(dir);
    assign anim_clr = dir_chg | ~anim_en;

    tick_divider #(.DIV(ANIM_DIV)) u_anim_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (anim_en),
        .clr_i  (anim_clr),
        .tick_o (anim_tick)
    );

    // A fresh alarm always starts on the visible phase.
    assign alarm_rise = alarm & ~alarm_q;
    assign blink_en   = alarm;
    assign blink_clr  = alarm_rise | ~alarm;

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (blink_en),
        .clr_i  (blink_clr),
        .tick_o (blink_tick)
    );

    // ------------------------------------------------------------------
    // Next-state for index, frame and phase
    // ------------------------------------------------------------------
    always_comb begin
        idx_d   = scan_tick ? idx_q + 1'b1 : idx_q;
        frame_d = anim_clr  ? 1'b0 : (anim_tick  ? ~frame_q : frame_q);
        phase_d = blink_clr ? 1'b0 : (blink_tick ? ~phase_q : phase_q);
    end

    // ------------------------------------------------------------------
    // Output sample. Frame and phase use their next values so the output
    // reflects a dir change / alarm rise on the same edge and each frame or
    // blink half lasts exactly DIV samples. The digit shown is the current
    // index, giving one cycle of latency from index to outputs.
    // ------------------------------------------------------------------
    always_comb begin
        out_d.code = C_OFF;
        out_d.an   = '1;
        if (enable) begin
            out_d.an = anode_sel(idx_q);
            if (alarm) begin
                out_d.code = phase_d ? C_OFF : C_ALARM;
            end else begin
                case (idx_q)
                    digit_idx_t'(0): out_d.code = floor_code(floor);
                    digit_idx_t'(1): out_d.code = dir_code(dir, frame_d);
                    default:         out_d.code = C_OFF;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            dir_q   <= DIR_IDLE;
            alarm_q <= 1'b0;
            frame_q <= 1'b0;
            phase_q <= 1'b0;
            out_q   <= '{code: C_OFF, an: '1};
        end else begin
            idx_q   <= idx_d;
            dir_q   <= dir;
            alarm_q <= alarm;
            frame_q <= frame_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

    assign code = out_q.code;
    assign an   = out_q.an;

endmodule
